// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: I2C strobe, host req/gnt and SRAM pins shared by the arbiter and its environment
// Ports: slave = arbiter view (drives gnt/rdata/mem_*), master = environment view (drives strobes, requests, mem_rdata).
interface sram_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          i2c_cs_n;
    logic          i2c_rw;
    logic [AW-1:0] i2c_addr;
    logic [DW-1:0] i2c_wdata;
    logic [DW-1:0] i2c_rdata;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    modport slave (
        input  i2c_cs_n, i2c_rw, i2c_addr, i2c_wdata, host_req, host_we, host_addr, host_wdata, mem_rdata,
        output i2c_rdata, host_gnt, host_rvalid, host_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output i2c_cs_n, i2c_rw, i2c_addr, i2c_wdata, host_req, host_we, host_addr, host_wdata, mem_rdata,
        input  i2c_rdata, host_gnt, host_rvalid, host_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between an I2C strobe port (priority, zero latency) and a host req/gnt port
// Ports: i_ck clock, i_rst sync active-high reset, bus (slave modport) carrying I2C strobe, host req/gnt and SRAM pins.
module sram_port_arbiter #(
    parameter int AW            = 8,
    parameter int DW            = 8,
    parameter int HOST_MAX_WAIT = 4
) (
    input logic                i_ck,
    input logic                i_rst,
    sram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_I2C, OWN_HOST} owner_t;
    localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);
    logic          pend_vld_q, pend_vld_d, pend_rw_q, pend_rw_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [DW-1:0] pend_wdata_q, pend_wdata_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    owner_t        owner_q, owner_d;
    logic [DW-1:0] i2c_rdata_q, i2c_rdata_d, host_rdata_q, host_rdata_d;
    logic          host_rvalid_q, host_rvalid_d;
    logic          i2c_new, host_win, capture, issue_host, issue_pend, issue_i2c;
    always_comb begin
        i2c_new    = bus.i2c_cs_n == 1'b0;
        host_win   = bus.host_req && wait_cnt_q == MAX_WAIT;
        issue_host = !i_rst && (host_win || (!pend_vld_q && !i2c_new && bus.host_req));
        issue_pend = !i_rst && !host_win && pend_vld_q;
        issue_i2c  = !i_rst && !host_win && !pend_vld_q && i2c_new;
        // a strobe that cannot go straight to the SRAM parks in pend; pend is refilled in the same cycle it drains
        capture      = i2c_new && (host_win || pend_vld_q);
        pend_vld_d   = capture || (pend_vld_q && !issue_pend);
        pend_rw_d    = capture ? bus.i2c_rw : pend_rw_q;
        pend_addr_d  = capture ? bus.i2c_addr : pend_addr_q;
        pend_wdata_d = capture ? bus.i2c_wdata : pend_wdata_q;
        wait_cnt_d   = (!bus.host_req || issue_host) ? 4'd0 :
                       (wait_cnt_q == MAX_WAIT) ? wait_cnt_q : wait_cnt_q + 4'd1;
        owner_d      = (issue_host && !bus.host_we) ? OWN_HOST :
                       ((issue_pend && pend_rw_q) || (issue_i2c && bus.i2c_rw)) ? OWN_I2C : OWN_NONE;
        i2c_rdata_d   = (owner_q == OWN_I2C) ? bus.mem_rdata : i2c_rdata_q;
        host_rdata_d  = (owner_q == OWN_HOST) ? bus.mem_rdata : host_rdata_q;
        host_rvalid_d = owner_q == OWN_HOST;
    end
    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            pend_vld_q    <= 1'b0;
            pend_rw_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_wdata_q  <= '0;
            wait_cnt_q    <= 4'd0;
            owner_q       <= OWN_NONE;
            i2c_rdata_q   <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            pend_vld_q    <= pend_vld_d;
            pend_rw_q     <= pend_rw_d;
            pend_addr_q   <= pend_addr_d;
            pend_wdata_q  <= pend_wdata_d;
            wait_cnt_q    <= wait_cnt_d;
            owner_q       <= owner_d;
            i2c_rdata_q   <= i2c_rdata_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end
    assign bus.mem_en      = issue_host || issue_pend || issue_i2c;
    assign bus.mem_we      = issue_host ? bus.host_we : issue_pend ? !pend_rw_q : issue_i2c && !bus.i2c_rw;
    assign bus.mem_addr    = issue_host ? bus.host_addr : issue_pend ? pend_addr_q : bus.i2c_addr;
    assign bus.mem_wdata   = issue_host ? bus.host_wdata : issue_pend ? pend_wdata_q : bus.i2c_wdata;
    assign bus.host_gnt    = issue_host;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.i2c_rdata   = i2c_rdata_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed self-checking bench for sram_port_arbiter with a behavioural SRAM model
module tb_sram_port_arbiter;
    logic i_ck = 1'b0;
    logic i_rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] mem [256];
    sram_port_arbiter_if #(.AW(8), .DW(8)) bus ();
    sram_port_arbiter #(.AW(8), .DW(8), .HOST_MAX_WAIT(4)) dut (.i_ck(i_ck), .i_rst(i_rst), .bus(bus));
    always #5 i_ck = ~i_ck;
    // SRAM: writes land at the edge, reads return one cycle after issue
    always @(posedge i_ck) begin
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) bus.mem_rdata <= mem[bus.mem_addr];
    end
    // a strobe arriving while the host wins and pend is still full would be lost
    always @(negedge i_ck) if (!i_rst) begin
        n_chk++;
        if (dut.host_win && dut.pend_vld_q && bus.i2c_cs_n === 1'b0) begin
            n_fail++;
            $display("FAIL pend_overwrite: pend valid=%0b while host wins, required 0", dut.pend_vld_q);
        end
    end
    task automatic step();
        @(posedge i_ck);
        #1;
    endtask
    task automatic idle();
        bus.i2c_cs_n = 1'b1;
        bus.i2c_rw = 1'bx;
        bus.i2c_addr = 8'h00;
        bus.i2c_wdata = 8'h00;
        bus.host_req = 1'b0;
        bus.host_we = 1'b0;
        bus.host_addr = 8'h00;
        bus.host_wdata = 8'h00;
    endtask
    task automatic test_reset();
        i_rst = 1'b1;
        bus.i2c_cs_n = 1'b0;
        bus.i2c_rw = 1'b1;
        bus.host_req = 1'b1;
        step();
        step();
        @(negedge i_ck);
        n_chk++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); end
        n_chk++; if (bus.host_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", bus.host_gnt); end
        n_chk++; if (bus.i2c_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_i2c_rdata: got %h want 00", bus.i2c_rdata); end
        n_chk++; if (bus.host_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_host_rdata: got %h want 00", bus.host_rdata); end
        n_chk++; if (bus.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", bus.host_rvalid); end
        idle();
        step();
        i_rst = 1'b0;
    endtask
    task automatic test_i2c_read();
        mem[8'h10] <= 8'hA5;
        step();
        bus.i2c_cs_n = 1'b0;
        bus.i2c_rw = 1'b1;
        bus.i2c_addr = 8'h10;
        @(negedge i_ck);
        n_chk++; if (bus.mem_en !== 1'b1) begin n_fail++; $display("FAIL i2c_rd_en: got %b want 1", bus.mem_en); end
        n_chk++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL i2c_rd_we: got %b want 0", bus.mem_we); end
        n_chk++; if (bus.mem_addr !== 8'h10) begin n_fail++; $display("FAIL i2c_rd_addr: got %h want 10", bus.mem_addr); end
        n_chk++; if (bus.host_gnt !== 1'b0) begin n_fail++; $display("FAIL i2c_rd_gnt: got %b want 0", bus.host_gnt); end
        step();
        idle();
        @(negedge i_ck);
        n_chk++; if (bus.i2c_rdata !== 8'h00) begin n_fail++; $display("FAIL i2c_rd_early: got %h want 00", bus.i2c_rdata); end
        step();
        @(negedge i_ck);
        n_chk++; if (bus.i2c_rdata !== 8'hA5) begin n_fail++; $display("FAIL i2c_rd_data: got %h want a5", bus.i2c_rdata); end
    endtask
    task automatic test_host_rw();
        step();
        bus.host_req = 1'b1;
        bus.host_we = 1'b1;
        bus.host_addr = 8'h20;
        bus.host_wdata = 8'h3C;
        @(negedge i_ck);
        n_chk++; if (bus.host_gnt !== 1'b1) begin n_fail++; $display("FAIL host_wr_gnt: got %b want 1", bus.host_gnt); end
        n_chk++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL host_wr_we: got %b want 1", bus.mem_we); end
        n_chk++; if (bus.mem_addr !== 8'h20) begin n_fail++; $display("FAIL host_wr_addr: got %h want 20", bus.mem_addr); end
        n_chk++; if (bus.mem_wdata !== 8'h3C) begin n_fail++; $display("FAIL host_wr_data: got %h want 3c", bus.mem_wdata); end
        step();
        idle();
        step();
        bus.host_req = 1'b1;
        bus.host_we = 1'b0;
        bus.host_addr = 8'h20;
        @(negedge i_ck);
        n_chk++; if (bus.host_gnt !== 1'b1) begin n_fail++; $display("FAIL host_rd_gnt: got %b want 1", bus.host_gnt); end
        n_chk++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL host_rd_we: got %b want 0", bus.mem_we); end
        step();
        idle();
        @(negedge i_ck);
        n_chk++; if (bus.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL host_rd_early: got %b want 0", bus.host_rvalid); end
        step();
        @(negedge i_ck);
        n_chk++; if (bus.host_rvalid !== 1'b1) begin n_fail++; $display("FAIL host_rd_rvalid: got %b want 1", bus.host_rvalid); end
        n_chk++; if (bus.host_rdata !== 8'h3C) begin n_fail++; $display("FAIL host_rd_data: got %h want 3c", bus.host_rdata); end
        step();
        @(negedge i_ck);
        n_chk++; if (bus.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL host_rd_pulse: got %b want 0", bus.host_rvalid); end
    endtask
    task automatic test_collision();
        mem[8'h11] <= 8'h5A;
        step();
        bus.i2c_cs_n = 1'b0;
        bus.i2c_rw = 1'b1;
        bus.i2c_addr = 8'h11;
        bus.host_req = 1'b1;
        bus.host_we = 1'b0;
        bus.host_addr = 8'h20;
        @(negedge i_ck);
        n_chk++; if (bus.mem_addr !== 8'h11) begin n_fail++; $display("FAIL coll_i2c_addr: got %h want 11", bus.mem_addr); end
        n_chk++; if (bus.host_gnt !== 1'b0) begin n_fail++; $display("FAIL coll_gnt0: got %b want 0", bus.host_gnt); end
        step();
        bus.i2c_cs_n = 1'b1;
        bus.i2c_rw = 1'bx;
        @(negedge i_ck);
        n_chk++; if (bus.host_gnt !== 1'b1) begin n_fail++; $display("FAIL coll_gnt1: got %b want 1", bus.host_gnt); end
        n_chk++; if (bus.mem_addr !== 8'h20) begin n_fail++; $display("FAIL coll_host_addr: got %h want 20", bus.mem_addr); end
        step();
        idle();
        @(negedge i_ck);
        n_chk++; if (bus.i2c_rdata !== 8'h5A) begin n_fail++; $display("FAIL coll_i2c_data: got %h want 5a", bus.i2c_rdata); end
        n_chk++; if (bus.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL coll_rvalid_early: got %b want 0", bus.host_rvalid); end
        step();
        @(negedge i_ck);
        n_chk++; if (bus.host_rvalid !== 1'b1) begin n_fail++; $display("FAIL coll_rvalid: got %b want 1", bus.host_rvalid); end
        n_chk++; if (bus.host_rdata !== 8'h3C) begin n_fail++; $display("FAIL coll_host_data: got %h want 3c", bus.host_rdata); end
    endtask
    task automatic test_starvation();
        int n_i2c = 0;
        int gnt_at = -1;
        logic got_gnt = 1'b0;
        logic [7:0] exp_addr;
        for (int i = 0; i < 8; i++) mem[i] <= 8'h40 + 8'(i);
        for (int c = 0; c < 10; c++) begin
            step();
            bus.i2c_cs_n = (c >= 8);
            bus.i2c_rw = 1'b1;
            bus.i2c_addr = 8'(c);
            bus.host_req = !got_gnt;
            bus.host_we = 1'b1;
            bus.host_addr = 8'h30;
            bus.host_wdata = 8'h99;
            @(negedge i_ck);
            if (bus.host_gnt === 1'b1) begin
                got_gnt = 1'b1;
                gnt_at = c;
                n_chk++; if (bus.mem_addr !== 8'h30) begin n_fail++; $display("FAIL starve_host_addr: got %h want 30", bus.mem_addr); end
            end else if (bus.mem_en === 1'b1) begin
                exp_addr = 8'(c < 4 ? c : c - 1);
                n_i2c++;
                n_chk++; if (bus.mem_addr !== exp_addr) begin n_fail++; $display("FAIL starve_i2c_addr c%0d: got %h want %h", c, bus.mem_addr, exp_addr); end
            end
        end
        idle();
        n_chk++; if (gnt_at != 4) begin n_fail++; $display("FAIL starve_gnt_cycle: got %0d want 4", gnt_at); end
        n_chk++; if (n_i2c != 8) begin n_fail++; $display("FAIL starve_i2c_count: got %0d want 8", n_i2c); end
        step();
        @(negedge i_ck);
        n_chk++; if (bus.i2c_rdata !== 8'h47) begin n_fail++; $display("FAIL starve_last_data: got %h want 47", bus.i2c_rdata); end
        n_chk++; if (mem[8'h30] !== 8'h99) begin n_fail++; $display("FAIL starve_host_wr: got %h want 99", mem[8'h30]); end
    endtask
    task automatic test_raw();
        step();
        bus.i2c_cs_n = 1'b0;
        bus.i2c_rw = 1'b0;
        bus.i2c_addr = 8'h05;
        bus.i2c_wdata = 8'h77;
        step();
        bus.i2c_rw = 1'b1;
        bus.i2c_wdata = 8'h00;
        step();
        bus.i2c_cs_n = 1'b1;
        bus.i2c_rw = 1'bx;
        @(negedge i_ck);
        n_chk++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL raw_x_ignored: got %b want 0", bus.mem_en); end
        step();
        @(negedge i_ck);
        n_chk++; if (bus.i2c_rdata !== 8'h77) begin n_fail++; $display("FAIL raw_i2c_data: got %h want 77", bus.i2c_rdata); end
        step();
        bus.host_req = 1'b1;
        bus.host_we = 1'b0;
        bus.host_addr = 8'h05;
        @(negedge i_ck);
        n_chk++; if (bus.host_gnt !== 1'b1) begin n_fail++; $display("FAIL raw_host_gnt: got %b want 1", bus.host_gnt); end
        step();
        idle();
        step();
        @(negedge i_ck);
        n_chk++; if (bus.host_rvalid !== 1'b1) begin n_fail++; $display("FAIL raw_host_rvalid: got %b want 1", bus.host_rvalid); end
        n_chk++; if (bus.host_rdata !== 8'h77) begin n_fail++; $display("FAIL raw_host_data: got %h want 77", bus.host_rdata); end
    endtask
    task automatic test_reset_mid();
        step();
        bus.host_req = 1'b1;
        bus.host_we = 1'b0;
        bus.host_addr = 8'h20;
        @(negedge i_ck);
        n_chk++; if (bus.host_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt: got %b want 1", bus.host_gnt); end
        step();
        i_rst = 1'b1;
        bus.i2c_cs_n = 1'b0;
        bus.i2c_rw = 1'b1;
        bus.i2c_addr = 8'h11;
        @(negedge i_ck);
        n_chk++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_en: got %b want 0", bus.mem_en); end
        n_chk++; if (bus.host_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_rst_gnt: got %b want 0", bus.host_gnt); end
        step();
        i_rst = 1'b0;
        idle();
        @(negedge i_ck);
        n_chk++; if (bus.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid: got %b want 0", bus.host_rvalid); end
        n_chk++; if (bus.i2c_rdata !== 8'h00) begin n_fail++; $display("FAIL mid_i2c_rdata: got %h want 00", bus.i2c_rdata); end
        n_chk++; if (bus.host_rdata !== 8'h00) begin n_fail++; $display("FAIL mid_host_rdata: got %h want 00", bus.host_rdata); end
        step();
        @(negedge i_ck);
        n_chk++; if (bus.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid_late: got %b want 0", bus.host_rvalid); end
        step();
        bus.host_req = 1'b1;
        bus.host_we = 1'b0;
        bus.host_addr = 8'h20;
        @(negedge i_ck);
        n_chk++; if (bus.host_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_regnt: got %b want 1", bus.host_gnt); end
        step();
        idle();
        step();
        @(negedge i_ck);
        n_chk++; if (bus.host_rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_re_rvalid: got %b want 1", bus.host_rvalid); end
        n_chk++; if (bus.host_rdata !== 8'h3C) begin n_fail++; $display("FAIL mid_re_data: got %h want 3c", bus.host_rdata); end
    endtask
    initial begin
        idle();
        test_reset();
        test_i2c_read();
        test_host_rw();
        test_collision();
        test_starvation();
        test_raw();
        test_reset_mid();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
